// File: rtl/laser_pkg.sv
// Shared types and constants for the lockstep multi-lane laser receiver.
// Parity support is selected in the top with the LASER_RX_PARITY_EN macro.
package laser_pkg;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    PARITY,
    STOP
  } rx_state_t;

  localparam logic START_BIT    = 1'b1;
  localparam logic STOP_BIT     = 1'b0;
  localparam int   VOTE_SAMPLES = 3;

  // Majority of three samples: at least two of them were high.
  function automatic logic majority(input logic [1:0] votes);
    return votes >= 2'd2;
  endfunction

endpackage

// File: rtl/laser_lane_sampler.sv
// Per-lane front end: 2-flop synchronizer, rising-edge detect, 3-sample vote,
// LSB-first payload shift register and running parity of the decided bits.
module laser_lane_sampler
  import laser_pkg::*;
#(
  parameter int DATA_W = 8
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              lane_i,
  input  logic              sample_i,
  input  logic              vote_clr_i,
  input  logic              shift_i,
  input  logic              par_clr_i,
  input  logic              par_bit_i,
  output logic              rise_o,
  output logic              vote_o,
  output logic [DATA_W-1:0] shreg_o,
  output logic              par_err_o
);

  logic              sync1_q, sync2_q, prev_q;
  logic [1:0]        vote_cnt_q;
  logic [DATA_W-1:0] shreg_q;
  logic              par_q;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
      prev_q  <= 1'b0;
    end else begin
      sync1_q <= lane_i;
      sync2_q <= sync1_q;
      prev_q  <= sync2_q;
    end
  end

  assign rise_o = sync2_q & ~prev_q;

  // Counts high samples inside the centre window; cleared at every bit decision.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      vote_cnt_q <= 2'd0;
    end else if (vote_clr_i) begin
      vote_cnt_q <= 2'd0;
    end else if (sample_i && sync2_q && (vote_cnt_q != 2'(VOTE_SAMPLES))) begin
      vote_cnt_q <= vote_cnt_q + 2'd1;
    end
  end

  assign vote_o = majority(vote_cnt_q);

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      shreg_q <= '0;
      par_q   <= 1'b0;
    end else begin
      if (shift_i) begin
        shreg_q <= {vote_o, shreg_q[DATA_W-1:1]};
      end
      if (par_clr_i) begin
        par_q <= 1'b0;
      end else if (shift_i || par_bit_i) begin
        par_q <= par_q ^ vote_o;
      end
    end
  end

  assign shreg_o   = shreg_q;
  assign par_err_o = par_q;

endmodule

// File: rtl/laser_lane_receiver.sv
// LANES-wide lockstep oversampling laser receiver with a single-entry output holding register.
// Define LASER_RX_PARITY_EN to add one even-parity bit per lane between data and stop.
module laser_lane_receiver
  import laser_pkg::*;
#(
  parameter int LANES      = 2,
  parameter int DATA_W     = 8,
  parameter int OVERSAMPLE = 8
) (
  input  logic                    clock,
  input  logic                    reset,
  input  logic                    en,
  input  logic [LANES-1:0]        laser_in,
  output logic [LANES*DATA_W-1:0] data_out,
  output logic [LANES-1:0]        frame_err,
  output logic                    data_valid,
  input  logic                    data_ready,
  output logic                    overrun,
  output logic                    busy
);

  localparam int MID    = OVERSAMPLE / 2;
  localparam int TICK_W = $clog2(OVERSAMPLE);
  localparam int BIT_W  = (DATA_W > 1) ? $clog2(DATA_W) : 1;
`ifdef LASER_RX_PARITY_EN
  localparam logic PAR_EN = 1'b1;
`else
  localparam logic PAR_EN = 1'b0;
`endif

  rx_state_t               state_q, state_d;
  logic [TICK_W-1:0]       tick_q, tick_d;
  logic [BIT_W-1:0]        bit_q, bit_d;
  logic [LANES*DATA_W-1:0] data_q, data_d;
  logic [LANES-1:0]        err_q, err_d;
  logic                    valid_q, valid_d;
  logic                    overrun_q, overrun_d;

  logic [LANES-1:0]        rise, vote, par_err, new_err;
  logic [LANES*DATA_W-1:0] shreg;
  logic                    decide, sample_en, vote_clr, shift_en, par_bit, par_clr, complete;

  assign decide    = (state_q != IDLE) && (tick_q == TICK_W'(OVERSAMPLE - 1));
  assign sample_en = (state_q != IDLE) && (tick_q >= TICK_W'(MID - 1)) && (tick_q <= TICK_W'(MID + 1));
  assign vote_clr  = !en || (state_q == IDLE) || decide;
  assign shift_en  = en && decide && (state_q == DATA);
  assign par_bit   = en && decide && (state_q == PARITY);
  assign par_clr   = (state_q == IDLE);

  for (genvar g = 0; g < LANES; g++) begin : g_lane
    laser_lane_sampler #(.DATA_W(DATA_W)) u_sampler (
      .clock      (clock),
      .reset      (reset),
      .lane_i     (laser_in[g]),
      .sample_i   (sample_en),
      .vote_clr_i (vote_clr),
      .shift_i    (shift_en),
      .par_clr_i  (par_clr),
      .par_bit_i  (par_bit),
      .rise_o     (rise[g]),
      .vote_o     (vote[g]),
      .shreg_o    (shreg[g*DATA_W +: DATA_W]),
      .par_err_o  (par_err[g])
    );
    assign new_err[g] = (vote[g] != STOP_BIT) | (PAR_EN & par_err[g]);
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      tick_q  <= '0;
      bit_q   <= '0;
    end else begin
      state_q <= state_d;
      tick_q  <= tick_d;
      bit_q   <= bit_d;
    end
  end

  // The rising-edge cycle counts as tick 0, so the first START cycle is tick 1.
  always_comb begin
    state_d  = state_q;
    tick_d   = tick_q;
    bit_d    = bit_q;
    complete = 1'b0;
    if (!en) begin
      state_d = IDLE;
      tick_d  = '0;
      bit_d   = '0;
    end else begin
      if (state_q != IDLE) begin
        tick_d = decide ? '0 : tick_q + TICK_W'(1);
      end
      case (state_q)
        IDLE: begin
          tick_d = '0;
          bit_d  = '0;
          if (|rise) begin
            state_d = START;
            tick_d  = TICK_W'(1);
          end
        end
        START: begin
          if (decide) begin
            state_d = (vote == {LANES{START_BIT}}) ? DATA : IDLE;
            bit_d   = '0;
          end
        end
        DATA: begin
          if (decide) begin
            if (bit_q == BIT_W'(DATA_W - 1)) begin
`ifdef LASER_RX_PARITY_EN
              state_d = PARITY;
`else
              state_d = STOP;
`endif
              bit_d = '0;
            end else begin
              bit_d = bit_q + BIT_W'(1);
            end
          end
        end
        PARITY: begin
          if (decide) state_d = STOP;
        end
        STOP: begin
          if (decide) begin
            state_d  = IDLE;
            complete = 1'b1;
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  // Output handshake: a frame is transferred on any cycle where data_valid && data_ready;
  // data_out/frame_err never change while data_valid is high and the frame is not being taken.
  // A frame completing while the holding register is full and not taken is dropped (overrun).
  always_comb begin
    data_d    = data_q;
    err_d     = err_q;
    valid_d   = valid_q & ~data_ready;
    overrun_d = 1'b0;
    if (complete) begin
      if (!valid_q || data_ready) begin
        data_d  = shreg;
        err_d   = new_err;
        valid_d = 1'b1;
      end else begin
        overrun_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      data_q    <= '0;
      err_q     <= '0;
      valid_q   <= 1'b0;
      overrun_q <= 1'b0;
    end else begin
      data_q    <= data_d;
      err_q     <= err_d;
      valid_q   <= valid_d;
      overrun_q <= overrun_d;
    end
  end

  assign data_out   = data_q;
  assign frame_err  = err_q;
  assign data_valid = valid_q;
  assign overrun    = overrun_q;
  assign busy       = (state_q != IDLE);

endmodule

// File: tb/tb_laser_lane_receiver.sv
// Directed bench for laser_lane_receiver (LANES=2, DATA_W=8, OVERSAMPLE=8); honours LASER_RX_PARITY_EN.
module tb_laser_lane_receiver;

  localparam int LANES  = 2;
  localparam int DATA_W = 8;
  localparam int OS     = 8;

  logic                    clock = 1'b0;
  logic                    reset;
  logic                    en;
  logic [LANES-1:0]        laser_in;
  logic [LANES*DATA_W-1:0] data_out;
  logic [LANES-1:0]        frame_err;
  logic                    data_valid;
  logic                    data_ready;
  logic                    overrun;
  logic                    busy;

  laser_lane_receiver #(.LANES(LANES), .DATA_W(DATA_W), .OVERSAMPLE(OS)) dut (
    .clock      (clock),
    .reset      (reset),
    .en         (en),
    .laser_in   (laser_in),
    .data_out   (data_out),
    .frame_err  (frame_err),
    .data_valid (data_valid),
    .data_ready (data_ready),
    .overrun    (overrun),
    .busy       (busy)
  );

  always #5 clock = ~clock;

  int pass_cnt  = 0;
  int total_cnt = 0;
  int ovr_cnt   = 0;
  logic [17:0] got_q[$];
  logic [17:0] exp_q[$];

  typedef struct {
    logic [7:0]  d0;
    logic [7:0]  d1;
    logic [1:0]  stop_v;
    logic [1:0]  pf;
    logic [15:0] exp_data;
    logic [1:0]  exp_err;
  } vec_t;

  vec_t vecs[6];

  // Handshakes are recorded one half-cycle before the edge that completes them.
  always @(negedge clock) begin
    if (data_valid && data_ready) got_q.push_back({frame_err, data_out});
    if (overrun) ovr_cnt++;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got %0h, expected %0h", name, act, exp);
  endtask

  task automatic drive_bit(input logic [1:0] v);
    laser_in = v;
    repeat (OS) @(posedge clock);
    #1;
  endtask

  task automatic send_frame(input logic [7:0] d0, input logic [7:0] d1,
                            input logic [1:0] stop_v, input logic [1:0] pf);
    drive_bit(2'b11);
    for (int i = 0; i < 8; i++) drive_bit({d1[i], d0[i]});
`ifdef LASER_RX_PARITY_EN
    drive_bit({^d1 ^ pf[1], ^d0 ^ pf[0]});
`else
    if (pf != 2'b00) laser_in = 2'b00;
`endif
    drive_bit(stop_v);
    drive_bit(2'b00);
  endtask

  task automatic wait_frame(input string name);
    int n;
    logic [17:0] f;
    logic [17:0] e;
    n = 0;
    e = exp_q.pop_front();
    while (got_q.size() == 0 && n < 64) begin
      @(negedge clock);
      n++;
    end
    if (got_q.size() == 0) begin
      total_cnt++;
      $display("FAIL %s: no frame within %0d cycles, expected data %0h err %0h", name, n, e[15:0], e[17:16]);
    end else begin
      f = got_q.pop_front();
      check($sformatf("%s data", name), 32'(f[15:0]), 32'(e[15:0]));
      check($sformatf("%s err", name), 32'(f[17:16]), 32'(e[17:16]));
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: bench did not finish in time");
    $fatal(1);
  end

  initial begin
    vecs[0] = '{8'hA5, 8'h3C, 2'b00, 2'b00, 16'h3CA5, 2'b00};
    vecs[1] = '{8'h11, 8'h22, 2'b10, 2'b00, 16'h2211, 2'b10};
`ifdef LASER_RX_PARITY_EN
    vecs[2] = '{8'h07, 8'h00, 2'b00, 2'b01, 16'h0007, 2'b01};
`else
    vecs[2] = '{8'h07, 8'h00, 2'b00, 2'b01, 16'h0007, 2'b00};
`endif
    vecs[3] = '{8'hFF, 8'h00, 2'b00, 2'b00, 16'h00FF, 2'b00};
    vecs[4] = '{8'h00, 8'hFF, 2'b11, 2'b00, 16'hFF00, 2'b11};
    vecs[5] = '{8'h80, 8'h01, 2'b00, 2'b00, 16'h0180, 2'b00};

    reset      = 1'b1;
    en         = 1'b0;
    data_ready = 1'b1;
    laser_in   = 2'b00;
    repeat (3) @(posedge clock);
    @(negedge clock);
    check("reset data_out", 32'(data_out), 32'h0);
    check("reset frame_err", 32'(frame_err), 32'h0);
    check("reset data_valid", 32'(data_valid), 32'h0);
    check("reset overrun", 32'(overrun), 32'h0);
    check("reset busy", 32'(busy), 32'h0);
    @(posedge clock);
    #1;
    reset = 1'b0;
    en    = 1'b1;
    repeat (4) @(posedge clock);
    #1;

    for (int v = 0; v < 6; v++) begin
      exp_q.push_back({vecs[v].exp_err, vecs[v].exp_data});
      send_frame(vecs[v].d0, vecs[v].d1, vecs[v].stop_v, vecs[v].pf);
      wait_frame($sformatf("vec%0d", v));
      repeat (2) @(negedge clock);
      check($sformatf("vec%0d single valid", v), 32'(got_q.size()), 32'd0);
      check($sformatf("vec%0d valid low", v), 32'(data_valid), 32'd0);
    end

    // Short glitch on lane 0: START must reject it within one bit period.
    laser_in = 2'b01;
    repeat (2) @(posedge clock);
    #1;
    laser_in = 2'b00;
    repeat (4) @(negedge clock);
    check("glitch busy high", 32'(busy), 32'd1);
    repeat (12) @(negedge clock);
    check("glitch busy dropped", 32'(busy), 32'd0);
    check("glitch no frame", 32'(got_q.size()), 32'd0);
    check("glitch valid low", 32'(data_valid), 32'd0);

    // Dropping en mid-frame aborts it without output.
    @(posedge clock);
    #1;
    drive_bit(2'b11);
    drive_bit(2'b01);
    drive_bit(2'b10);
    en = 1'b0;
    @(negedge clock);
    @(negedge clock);
    check("abort busy", 32'(busy), 32'd0);
    laser_in = 2'b00;
    repeat (OS * 12) @(posedge clock);
    #1;
    en = 1'b1;
    repeat (4) @(posedge clock);
    #1;
    check("abort no frame", 32'(got_q.size()), 32'd0);

    // Consumer stalled: second frame is dropped with a single overrun pulse.
    data_ready = 1'b0;
    ovr_cnt    = 0;
    send_frame(8'h01, 8'h02, 2'b00, 2'b00);
    send_frame(8'h03, 8'h04, 2'b00, 2'b00);
    @(negedge clock);
    check("overrun pulses", 32'(ovr_cnt), 32'd1);
    check("overrun held valid", 32'(data_valid), 32'd1);
    check("overrun held data", 32'(data_out), 32'h0201);
    check("overrun held err", 32'(frame_err), 32'h0);
    @(posedge clock);
    #1;
    data_ready = 1'b1;
    exp_q.push_back({2'b00, 16'h0201});
    wait_frame("overrun drain");
    repeat (3) @(negedge clock);
    check("overrun only one frame", 32'(got_q.size()), 32'd0);
    check("overrun valid cleared", 32'(data_valid), 32'd0);
    check("overrun no more pulses", 32'(ovr_cnt), 32'd1);

    // Reset during data bit 4 discards the partial frame and zeroes the outputs.
    drive_bit(2'b11);
    for (int i = 0; i < 4; i++) drive_bit(2'b01);
    repeat (3) @(posedge clock);
    #1;
    check("pre-reset busy", 32'(busy), 32'd1);
    reset    = 1'b1;
    laser_in = 2'b00;
    @(negedge clock);
    check("mid reset busy", 32'(busy), 32'd0);
    check("mid reset data_out", 32'(data_out), 32'h0);
    check("mid reset frame_err", 32'(frame_err), 32'h0);
    check("mid reset valid", 32'(data_valid), 32'd0);
    repeat (3) @(posedge clock);
    #1;
    reset = 1'b0;
    repeat (OS * 2) @(posedge clock);
    #1;
    check("post reset no frame", 32'(got_q.size()), 32'd0);
    exp_q.push_back({2'b00, 16'h00FF});
    send_frame(8'hFF, 8'h00, 2'b00, 2'b00);
    wait_frame("after reset");

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
